// File: rtl/twiddle_gen_pkg.sv
// Shared types, constants and elaboration-time helpers for the twiddle generator.
// The quarter-wave cosine table is computed here with integer arithmetic so no data file is needed.
package twiddle_gen_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  localparam int LOG2N_MIN = 4;
  localparam int LOG2N_MAX = 14;

  function automatic int quarter_depth(input int n);
    return n / 4 + 1;
  endfunction

  // Largest positive Q1.(width-1) value, standing in for 1.0
  function automatic longint one_q(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic bit log2n_ok(input int log2n);
    return (log2n >= LOG2N_MIN) && (log2n <= LOG2N_MAX);
  endfunction

  // sat(round(cos(2*pi*i/N) * 2^(width-1))) via a Q30 Taylor series; angle never exceeds pi/2
  function automatic longint quarter_cos(input int i, input int log2n, input int width);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint res;
    x    = (64'sd6746518852 * longint'(i)) >>> log2n;
    x2   = (x * x) >>> 30;
    term = 64'sd1 <<< 30;
    sum  = term;
    for (int n = 1; n <= 10; n++) begin
      term = -(((term * x2) >>> 30) / longint'((2 * n - 1) * (2 * n)));
      sum  = sum + term;
    end
    res = ((sum <<< (width - 1)) + (64'sd1 <<< 29)) >>> 30;
    if (res > one_q(width)) begin
      res = one_q(width);
    end else if (res < 0) begin
      res = 0;
    end
    return res;
  endfunction

endpackage

// File: rtl/twiddle_gen_if.sv
// Index-in / twiddle-out stream bundle between the FFT address sequencer and the butterfly.
interface twiddle_gen_if #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [LOG2N-1:0] k;
  logic             inverse;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] re;
  logic [WIDTH-1:0] im;

  modport master (
    output in_valid, k, inverse, out_ready,
    input  in_ready, out_valid, re, im
  );

  modport slave (
    input  in_valid, k, inverse, out_ready,
    output in_ready, out_valid, re, im
  );
endinterface

// File: rtl/twiddle_quarter_rom.sv
// Two-read-port synchronous quarter-wave cosine ROM (N/4+1 words); pure storage, no folding.
module twiddle_quarter_rom
  import twiddle_gen_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LOG2N = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic [LOG2N-2:0] addr_a,
  input  logic [LOG2N-2:0] addr_b,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b
);
  localparam int DEPTH = quarter_depth(1 << LOG2N);

  logic [WIDTH-1:0] rom [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_table
      assign rom[gi] = WIDTH'(quarter_cos(gi, LOG2N, WIDTH));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (en) begin
      data_a <= rom[addr_a];
      data_b <= rom[addr_b];
    end
  end
endmodule

// File: rtl/twiddle_gen.sv
// Three-stage twiddle generator: S1 quadrant decode, S2 dual ROM read, S3 quadrant fold and sign.
// One global advance signal stalls every stage together while the output is held.
module twiddle_gen
  import twiddle_gen_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LOG2N = 10
) (
  input logic         clk,
  input logic         rst,
  twiddle_gen_if.slave tw
);
  localparam int AW = LOG2N - 1;
  localparam logic [AW-1:0] QUARTER = AW'(quarter_depth(1 << LOG2N) - 1);

  generate
    if (!log2n_ok(LOG2N)) begin : g_bad_log2n
      $error("twiddle_gen: LOG2N must be within 4..14");
    end
  endgenerate

  logic             adv;
  logic             v1_reg, v2_reg, v3_reg;
  quad_e            q1_reg, q2_reg;
  logic [LOG2N-3:0] r1_reg;
  logic             inv1_reg, inv2_reg;
  logic [AW-1:0]    addr_a, addr_b;
  logic [WIDTH-1:0] a_data, b_data;
  logic [WIDTH-1:0] cos_v, sin_v;
  logic [WIDTH-1:0] re_next, im_next;
  logic [WIDTH-1:0] re_reg, im_reg;

  assign adv         = !v3_reg || tw.out_ready;
  assign tw.in_ready = adv;
  assign tw.out_valid = v3_reg;
  assign tw.re       = re_reg;
  assign tw.im       = im_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg <= 1'b0;
    end else if (adv) begin
      v1_reg <= tw.in_valid;
      if (tw.in_valid) begin
        q1_reg   <= quad_e'(tw.k[LOG2N-1 -: 2]);
        r1_reg   <= tw.k[LOG2N-3:0];
        inv1_reg <= tw.inverse;
      end
    end
  end

  // Mirror index N/4-r stays in range: r=0 lands exactly on the zero entry
  assign addr_a = {1'b0, r1_reg};
  assign addr_b = QUARTER - addr_a;

  twiddle_quarter_rom #(
    .WIDTH(WIDTH),
    .LOG2N(LOG2N)
  ) u_rom (
    .clk   (clk),
    .en    (adv),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .data_a(a_data),
    .data_b(b_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_reg <= 1'b0;
    end else if (adv) begin
      v2_reg   <= v1_reg;
      q2_reg   <= q1_reg;
      inv2_reg <= inv1_reg;
    end
  end

  // Table never holds the most-negative code, so plain negation cannot overflow
  always_comb begin
    cos_v = a_data;
    sin_v = b_data;
    case (q2_reg)
      Q0: begin cos_v = a_data;  sin_v = b_data;  end
      Q1: begin cos_v = -b_data; sin_v = a_data;  end
      Q2: begin cos_v = -a_data; sin_v = -b_data; end
      Q3: begin cos_v = b_data;  sin_v = -a_data; end
      default: begin cos_v = a_data; sin_v = b_data; end
    endcase
    re_next = cos_v;
    im_next = inv2_reg ? sin_v : -sin_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3_reg <= 1'b0;
      re_reg <= '0;
      im_reg <= '0;
    end else if (adv) begin
      v3_reg <= v2_reg;
      if (v2_reg) begin
        re_reg <= re_next;
        im_reg <= im_next;
      end
    end
  end
endmodule

// File: tb/tb_twiddle_gen.sv
// Randomised self-checking bench for twiddle_gen against a real-valued cos/sin model.
module tb_twiddle_gen;
  localparam int  WIDTH = 16;
  localparam int  LOG2N = 10;
  localparam int  N     = 1 << LOG2N;
  localparam real PI    = 3.14159265358979323846;

  typedef struct {
    int k;
    bit inv;
  } txn_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  twiddle_gen_if #(.WIDTH(WIDTH), .LOG2N(LOG2N)) tw_if ();

  twiddle_gen #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
    .clk(clk),
    .rst(rst),
    .tw (tw_if)
  );

  int   errors = 0;
  int   checks = 0;
  txn_t sb[$];

  logic             obs_in_ready;
  logic             obs_out_valid;
  logic [WIDTH-1:0] obs_re;
  logic [WIDTH-1:0] obs_im;

  function automatic real model_re(input int kk);
    return $cos(2.0 * PI * real'(kk) / real'(N)) * 32768.0;
  endfunction

  function automatic real model_im(input int kk, input bit inv);
    real s;
    s = $sin(2.0 * PI * real'(kk) / real'(N)) * 32768.0;
    return inv ? s : -s;
  endfunction

  // Drive one cycle from a falling edge, sample just after, then move to the next falling edge
  task automatic step(input bit iv, input int kk, input bit inv, input bit ordy);
    logic [31:0] kv;
    kv = kk;
    tw_if.in_valid  = iv;
    tw_if.k         = kv[LOG2N-1:0];
    tw_if.inverse   = inv;
    tw_if.out_ready = ordy;
    #1;
    obs_in_ready  = tw_if.in_ready;
    obs_out_valid = tw_if.out_valid;
    obs_re        = tw_if.re;
    obs_im        = tw_if.im;
    if (iv && obs_in_ready) sb.push_back(txn_t'{k: kk, inv: inv});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    tw_if.in_valid  = 1'b0;
    tw_if.k         = '0;
    tw_if.inverse   = 1'b0;
    tw_if.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (tw_if.out_valid !== 1'b0 || tw_if.re !== 16'h0 || tw_if.im !== 16'h0) begin
      errors++;
      $display("FAIL reset_state out_valid=%b re=%h im=%h required 0/0000/0000",
               tw_if.out_valid, tw_if.re, tw_if.im);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (tw_if.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 1", tw_if.in_ready);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (obs_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d out_valid=%b required 0", i, obs_out_valid);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_spot();
    int          ks   [7] = '{0, 128, 128, 256, 512, 768, 768};
    bit          invs [7] = '{0, 0, 1, 0, 0, 0, 1};
    logic [15:0] res  [7] = '{16'h7FFF, 16'h5A82, 16'h5A82, 16'h0000, 16'h8001, 16'h0000, 16'h0000};
    logic [15:0] ims  [7] = '{16'h0000, 16'hA57E, 16'h5A82, 16'h8001, 16'h0000, 16'h7FFF, 16'h8001};
    for (int i = 0; i < 7; i++) begin
      step(1'b1, ks[i], invs[i], 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (obs_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL spot_early k=%0d out_valid=%b required 0 two clk after accept", ks[i], obs_out_valid);
      end
      step(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (obs_out_valid !== 1'b1 || obs_re !== res[i] || obs_im !== ims[i]) begin
        errors++;
        $display("FAIL spot k=%0d inv=%0d got v=%b re=%h im=%h required v=1 re=%h im=%h",
                 ks[i], invs[i], obs_out_valid, obs_re, obs_im, res[i], ims[i]);
      end
      if (sb.size() > 0) void'(sb.pop_front());
      step(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (obs_out_valid !== 1'b0 || obs_re !== res[i] || obs_im !== ims[i]) begin
        errors++;
        $display("FAIL spot_bubble k=%0d got v=%b re=%h im=%h required v=0 re=%h im=%h",
                 ks[i], obs_out_valid, obs_re, obs_im, res[i], ims[i]);
      end
      $display("spot k=%0d inv=%0d re=%h im=%h", ks[i], invs[i], res[i], ims[i]);
    end
  endtask

  task automatic test_sweep();
    txn_t t;
    real  d_re;
    real  d_im;
    int   seen = 0;
    sb.delete();
    for (int c = 0; c < N + 3; c++) begin
      step(c < N, c, 1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if (obs_out_valid !== (c >= 3)) begin
        errors++;
        $display("FAIL sweep_valid cycle %0d out_valid=%b required %b", c, obs_out_valid, c >= 3);
      end
      if (obs_out_valid === 1'b1 && sb.size() > 0) begin
        t    = sb.pop_front();
        seen++;
        d_re = real'($signed(obs_re)) - model_re(t.k);
        d_im = real'($signed(obs_im)) - model_im(t.k, t.inv);
        checks++;
        if (d_re > 1.0 || d_re < -1.0 || d_im > 1.0 || d_im < -1.0) begin
          errors++;
          $display("FAIL sweep k=%0d inv=%0d got re=%h im=%h required re=%f im=%f",
                   t.k, t.inv, obs_re, obs_im, model_re(t.k), model_im(t.k, t.inv));
        end
      end
    end
    checks++;
    if (seen != N || sb.size() != 0) begin
      errors++;
      $display("FAIL sweep_count got %0d outputs (%0d left) required %0d", seen, sb.size(), N);
    end
    $display("sweep outputs=%0d", seen);
  endtask

  task automatic test_back_to_back_stall();
    txn_t        t;
    real         d_re;
    real         d_im;
    bit          ordy;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_re    = '0;
    logic [15:0] prev_im    = '0;
    int          outs       = 0;
    int          ins        = 0;
    sb.delete();
    for (int c = 0; c < 1500; c++) begin
      bit drain;
      drain = (c >= 1400);
      ordy  = drain ? 1'b1 : 1'($urandom_range(0, 1));
      step(!drain && ($urandom_range(0, 9) < 7), int'($urandom_range(0, N - 1)),
           1'($urandom_range(0, 1)), ordy);
      if (!drain && tw_if.in_valid && obs_in_ready) ins++;
      checks++;
      if (obs_in_ready !== (!obs_out_valid || ordy)) begin
        errors++;
        $display("FAIL stall_in_ready cycle %0d got %b required %b", c, obs_in_ready, !obs_out_valid || ordy);
      end
      if (prev_stall) begin
        checks++;
        if (obs_out_valid !== 1'b1 || obs_re !== prev_re || obs_im !== prev_im) begin
          errors++;
          $display("FAIL stall_hold cycle %0d got v=%b re=%h im=%h required v=1 re=%h im=%h",
                   c, obs_out_valid, obs_re, obs_im, prev_re, prev_im);
        end
      end
      if (obs_out_valid === 1'b1 && ordy) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL stall_dup cycle %0d got extra output re=%h im=%h required none", c, obs_re, obs_im);
        end else begin
          t    = sb.pop_front();
          outs++;
          d_re = real'($signed(obs_re)) - model_re(t.k);
          d_im = real'($signed(obs_im)) - model_im(t.k, t.inv);
          if (d_re > 1.0 || d_re < -1.0 || d_im > 1.0 || d_im < -1.0) begin
            errors++;
            $display("FAIL stall_data k=%0d inv=%0d got re=%h im=%h required re=%f im=%f",
                     t.k, t.inv, obs_re, obs_im, model_re(t.k), model_im(t.k, t.inv));
          end
        end
      end
      prev_stall = (obs_out_valid === 1'b1) && !ordy;
      prev_re    = obs_re;
      prev_im    = obs_im;
    end
    checks++;
    if (sb.size() != 0 || outs != ins) begin
      errors++;
      $display("FAIL stall_loss got %0d outputs for %0d inputs (%0d pending) required equal",
               outs, ins, sb.size());
    end
    $display("stall accepted=%0d delivered=%0d", ins, outs);
  endtask

  task automatic test_reset_midflight();
    txn_t t;
    real  d_re;
    real  d_im;
    step(1'b1, 1, 1'b0, 1'b1);
    step(1'b1, 2, 1'b0, 1'b1);
    step(1'b1, 3, 1'b0, 1'b1);
    tw_if.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    checks++;
    if (tw_if.out_valid !== 1'b0 || tw_if.re !== 16'h0 || tw_if.im !== 16'h0) begin
      errors++;
      $display("FAIL midreset_state got v=%b re=%h im=%h required 0/0000/0000",
               tw_if.out_valid, tw_if.re, tw_if.im);
    end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (obs_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale cycle %0d out_valid=%b required 0", i, obs_out_valid);
      end
    end
    step(1'b1, 5, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (obs_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_early out_valid=%b required 0", obs_out_valid);
    end
    step(1'b0, 0, 1'b0, 1'b1);
    checks++;
    if (obs_out_valid !== 1'b1 || sb.size() != 1) begin
      errors++;
      $display("FAIL midreset_latency got v=%b pending=%0d required v=1 pending=1", obs_out_valid, sb.size());
    end else begin
      t    = sb.pop_front();
      d_re = real'($signed(obs_re)) - model_re(t.k);
      d_im = real'($signed(obs_im)) - model_im(t.k, t.inv);
      checks++;
      if (t.k != 5 || d_re > 1.0 || d_re < -1.0 || d_im > 1.0 || d_im < -1.0) begin
        errors++;
        $display("FAIL midreset_data k=%0d got re=%h im=%h required re=%f im=%f",
                 t.k, obs_re, obs_im, model_re(5), model_im(5, 1'b0));
      end
    end
    $display("midflight reset k=5 re=%h im=%h", obs_re, obs_im);
  endtask

  initial begin
    test_reset();
    test_spot();
    test_sweep();
    test_back_to_back_stall();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
